// File: rtl/router_out_port_if.sv
// Egress port bundle: core-side byte write channel plus the reader-side ready/read/data port.
// Write: a byte moves when wr_valid && wr_ready on a clock edge; read: a byte pops when read && ready.
interface router_out_port_if #(
    parameter int CW = 7
);
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          wr_last;
    logic          wr_ready;
    logic          ready;
    logic          read;
    logic [7:0]    data;
    logic [CW-1:0] pkt_count;
    logic          ovf_err;

    modport master (
        output wr_valid, wr_data, wr_last, read,
        input  wr_ready, ready, data, pkt_count, ovf_err
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, read,
        output wr_ready, ready, data, pkt_count, ovf_err
    );
endinterface

// File: rtl/router_out_port.sv
// Output-port packet buffer: stores whole packets from the routing core and serves them
// byte-by-byte to the port reader, with a one-cycle ready=0 gap between packets.
module router_out_port #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int CW    = 7
) (
    input  logic              clock,
    input  logic              reset,
    router_out_port_if.slave  port,
    output logic [1:0]        state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] pkt_count_q;
    logic [7:0]    data_q;
    logic          ovf_q;

    logic full;
    logic wr_fire;
    logic commit;
    logic ready_int;
    logic pop;
    logic pop_last;
    logic [8:0] rd_entry;

    // Same index with differing wrap bits means every entry is occupied.
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    // Held low while reset is asserted; full is evaluated before any same-cycle pop.
    assign port.wr_ready = reset && !full;
    assign wr_fire   = port.wr_valid && port.wr_ready;
    assign commit    = wr_fire && port.wr_last;

    assign ready_int = (state == S_SEND) || ((state == S_IDLE) && (pkt_count_q != '0));
    assign pop       = port.read && ready_int;
    assign rd_entry  = mem[rd_ptr[AW-1:0]];
    assign pop_last  = pop && rd_entry[8];

    assign port.ready     = ready_int;
    assign port.data      = data_q;
    assign port.pkt_count = pkt_count_q;
    assign port.ovf_err   = ovf_q;
    assign state_dbg      = state;

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= {port.wr_last, port.wr_data};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = pop_last ? S_GAP : S_SEND;
                end
            end
            S_SEND: begin
                if (pop_last) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= S_IDLE;
            pkt_count_q <= '0;
            data_q      <= 8'h00;
            ovf_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                data_q <= rd_entry[7:0];
            end
            // A commit and a final pop in the same cycle cancel out.
            if (commit && !pop_last) begin
                pkt_count_q <= pkt_count_q + CNT_ONE;
            end else if (!commit && pop_last) begin
                pkt_count_q <= pkt_count_q - CNT_ONE;
            end
            if (port.wr_valid && !port.wr_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end
endmodule
